dbg_halt_ctrl: RTL and testbench

Debug halt controller that produces the `dbg2ac_stall` request consumed by the pipeline auxiliary control unit. It sequences halt requests, ebreak entry and single-step from the debug module into a pipeline freeze, drains outstanding memory and writeback activity, then reports halted status, cause and DPC. On resume it releases the stall and optionally arms a single step. It sits between the debug module and the pipeline control unit, beside the CSR unit.

---
 rtl/dbg_halt_ctrl_if.sv | 64 ++++++
 rtl/dbg_halt_ctrl.sv | 153 +++++++++++++++
 tb/tb_dbg_halt_ctrl.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/dbg_halt_ctrl_if.sv
// Signal bundle between the debug module / pipeline control unit and the debug halt controller.
// The master side drives requests and pipeline status; the slave side is the halt controller.
interface dbg_halt_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic              dm_halt_req;
    logic              dm_resume_req;
    logic              dm_step_en;
    logic              dm_ebreakm;
    logic              wb_ebreak;
    logic              wb_retire;
    logic [ADDR_W-1:0] retire_next_pc;
    logic              trap_jump_valid;
    logic [ADDR_W-1:0] trap_jump_pc;
    logic              lsu2ac_hazard;
    logic              wb2ac_hazard;

    logic              dbg2ac_stall;
    logic              dm_halted;
    logic              dm_resume_ack;
    logic [2:0]        dbg_cause;
    logic [ADDR_W-1:0] dbg_dpc;
    logic              dbg_halt_timeout;

    modport master (
        output dm_halt_req,
        output dm_resume_req,
        output dm_step_en,
        output dm_ebreakm,
        output wb_ebreak,
        output wb_retire,
        output retire_next_pc,
        output trap_jump_valid,
        output trap_jump_pc,
        output lsu2ac_hazard,
        output wb2ac_hazard,
        input  dbg2ac_stall,
        input  dm_halted,
        input  dm_resume_ack,
        input  dbg_cause,
        input  dbg_dpc,
        input  dbg_halt_timeout
    );

    modport slave (
        input  dm_halt_req,
        input  dm_resume_req,
        input  dm_step_en,
        input  dm_ebreakm,
        input  wb_ebreak,
        input  wb_retire,
        input  retire_next_pc,
        input  trap_jump_valid,
        input  trap_jump_pc,
        input  lsu2ac_hazard,
        input  wb2ac_hazard,
        output dbg2ac_stall,
        output dm_halted,
        output dm_resume_ack,
        output dbg_cause,
        output dbg_dpc,
        output dbg_halt_timeout
    );
endinterface

// File: rtl/dbg_halt_ctrl.sv
// Debug halt controller: turns halt requests, ebreak and single-step into a pipeline freeze,
// waits for memory/writeback to drain, then reports halted status, cause and DPC.
module dbg_halt_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int HALT_TO = 255
) (
    input  logic           clk,
    input  logic           rst,
    dbg_halt_ctrl_if.slave bus
);

    localparam int CNT_W = $clog2(HALT_TO + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HALT_TO);

    localparam logic [2:0] CAUSE_EBREAK  = 3'd1;
    localparam logic [2:0] CAUSE_HALTREQ = 3'd3;
    localparam logic [2:0] CAUSE_STEP    = 3'd4;

    typedef enum logic [2:0] {
        S_RUN,
        S_DRAIN,
        S_HALTED,
        S_RESUME,
        S_STEP
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_step_armed;
    logic              w_step_armed_nxt;
    logic [2:0]        r_cause;
    logic [2:0]        w_cause_nxt;
    logic [ADDR_W-1:0] r_dpc;
    logic [ADDR_W-1:0] w_dpc_nxt;
    logic              r_timeout;
    logic              w_timeout_nxt;
    logic              r_stall;
    logic              r_halted;
    logic              r_ack;
    logic              w_ebreak_hit;
    logic              w_hazard;
    logic [ADDR_W-1:0] w_halt_dpc;

    assign w_ebreak_hit = bus.wb_ebreak & bus.dm_ebreakm;
    assign w_hazard     = bus.lsu2ac_hazard | bus.wb2ac_hazard;
    // A halt landing on a trap redirect must resume at the trap target, not the faulting PC.
    assign w_halt_dpc   = bus.trap_jump_valid ? bus.trap_jump_pc : bus.retire_next_pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_RUN;
            r_cause      <= 3'd0;
            r_dpc        <= '0;
            r_step_armed <= 1'b0;
            r_timeout    <= 1'b0;
            r_stall      <= 1'b0;
            r_halted     <= 1'b0;
            r_ack        <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_cause      <= w_cause_nxt;
            r_dpc        <= w_dpc_nxt;
            r_step_armed <= w_step_armed_nxt;
            r_timeout    <= w_timeout_nxt;
            r_stall      <= (w_next == S_DRAIN) || (w_next == S_HALTED);
            r_halted     <= (w_next == S_HALTED);
            r_ack        <= (w_next == S_RESUME);
        end
    end

    // Held at zero outside DRAIN so every drain starts counting from zero; saturates at the limit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (r_state != S_DRAIN) begin
            r_cnt <= '0;
        end else if (r_cnt != CNT_MAX) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_comb begin
        w_next           = r_state;
        w_cause_nxt      = r_cause;
        w_dpc_nxt        = r_dpc;
        w_step_armed_nxt = r_step_armed;
        w_timeout_nxt    = r_timeout;

        unique case (r_state)
            S_RUN: begin
                if (w_ebreak_hit) begin
                    w_next      = S_DRAIN;
                    w_cause_nxt = CAUSE_EBREAK;
                    w_dpc_nxt   = bus.retire_next_pc;
                end else if (bus.dm_halt_req) begin
                    w_next      = S_DRAIN;
                    w_cause_nxt = CAUSE_HALTREQ;
                    w_dpc_nxt   = w_halt_dpc;
                end
            end
            S_DRAIN: begin
                if (!w_hazard) begin
                    w_next = S_HALTED;
                end else if (r_cnt == CNT_MAX) begin
                    w_next        = S_HALTED;
                    w_timeout_nxt = 1'b1;
                end
            end
            S_HALTED: begin
                // Timeout flag drops as RESUME is entered so the ack cycle already shows it clear.
                if (bus.dm_resume_req) begin
                    w_next           = S_RESUME;
                    w_step_armed_nxt = bus.dm_step_en;
                    w_timeout_nxt    = 1'b0;
                end
            end
            S_RESUME: begin
                w_next = r_step_armed ? S_STEP : S_RUN;
            end
            S_STEP: begin
                if (w_ebreak_hit) begin
                    w_next      = S_DRAIN;
                    w_cause_nxt = CAUSE_EBREAK;
                    w_dpc_nxt   = bus.retire_next_pc;
                end else if (bus.dm_halt_req) begin
                    w_next      = S_DRAIN;
                    w_cause_nxt = CAUSE_HALTREQ;
                    w_dpc_nxt   = w_halt_dpc;
                end else if (bus.trap_jump_valid) begin
                    w_next      = S_DRAIN;
                    w_cause_nxt = CAUSE_STEP;
                    w_dpc_nxt   = bus.trap_jump_pc;
                end else if (bus.wb_retire) begin
                    w_next      = S_DRAIN;
                    w_cause_nxt = CAUSE_STEP;
                    w_dpc_nxt   = bus.retire_next_pc;
                end
            end
            default: begin
                w_next = S_RUN;
            end
        endcase
    end

    assign bus.dbg2ac_stall     = r_stall;
    assign bus.dm_halted        = r_halted;
    assign bus.dm_resume_ack    = r_ack;
    assign bus.dbg_cause        = r_cause;
    assign bus.dbg_dpc          = r_dpc;
    assign bus.dbg_halt_timeout = r_timeout;

endmodule

// File: tb/tb_dbg_halt_ctrl.sv
// Self-checking bench for dbg_halt_ctrl: table of per-cycle vectors with a scoreboard,
// plus a hand-written timeout sequence on a second instance with a short drain limit.
module tb_dbg_halt_ctrl;

    localparam int ADDR_W   = 32;
    localparam int SHORT_TO = 4;

    localparam logic [9:0] IDLE = 10'h000;
    localparam logic [9:0] RST  = 10'h200;
    localparam logic [9:0] HRQ  = 10'h100;
    localparam logic [9:0] RSM  = 10'h080;
    localparam logic [9:0] STP  = 10'h040;
    localparam logic [9:0] EBM  = 10'h020;
    localparam logic [9:0] EBK  = 10'h010;
    localparam logic [9:0] RET  = 10'h008;
    localparam logic [9:0] TRV  = 10'h004;
    localparam logic [9:0] LSU  = 10'h002;
    localparam logic [9:0] WBH  = 10'h001;

    // Flag bundle order: stall, halted, resume_ack, timeout
    localparam logic [3:0] NONE = 4'b0000;
    localparam logic [3:0] ST   = 4'b1000;
    localparam logic [3:0] HL   = 4'b0100;
    localparam logic [3:0] AK   = 4'b0010;
    localparam logic [3:0] TO   = 4'b0001;

    localparam logic [31:0] P40  = 32'h8000_0040;
    localparam logic [31:0] P44  = 32'h8000_0044;
    localparam logic [31:0] P80  = 32'h8000_0080;
    localparam logic [31:0] P100 = 32'h8000_0100;
    localparam logic [31:0] P200 = 32'h8000_0200;
    localparam logic [31:0] P300 = 32'h8000_0300;
    localparam logic [31:0] P400 = 32'h8000_0400;
    localparam logic [31:0] P500 = 32'h8000_0500;

    typedef struct {
        logic [9:0]  stim;
        logic [31:0] pc;
        logic [31:0] tpc;
        logic [3:0]  flags;
        logic [2:0]  cause;
        logic [31:0] dpc;
    } vec_t;

    typedef struct {
        logic [3:0]  flags;
        logic [2:0]  cause;
        logic [31:0] dpc;
        int          idx;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    vec_t vecs[$];
    exp_t sb[$];

    always #5 clk = ~clk;

    dbg_halt_ctrl_if #(.ADDR_W(ADDR_W)) busA();
    dbg_halt_ctrl_if #(.ADDR_W(ADDR_W)) busB();

    dbg_halt_ctrl #(.ADDR_W(ADDR_W)) dutA (
        .clk (clk),
        .rst (rst),
        .bus (busA)
    );

    dbg_halt_ctrl #(.ADDR_W(ADDR_W), .HALT_TO(SHORT_TO)) dutB (
        .clk (clk),
        .rst (rst),
        .bus (busB)
    );

    assign busB.dm_halt_req     = busA.dm_halt_req;
    assign busB.dm_resume_req   = busA.dm_resume_req;
    assign busB.dm_step_en      = busA.dm_step_en;
    assign busB.dm_ebreakm      = busA.dm_ebreakm;
    assign busB.wb_ebreak       = busA.wb_ebreak;
    assign busB.wb_retire       = busA.wb_retire;
    assign busB.retire_next_pc  = busA.retire_next_pc;
    assign busB.trap_jump_valid = busA.trap_jump_valid;
    assign busB.trap_jump_pc    = busA.trap_jump_pc;
    assign busB.lsu2ac_hazard   = busA.lsu2ac_hazard;
    assign busB.wb2ac_hazard    = busA.wb2ac_hazard;

    function automatic void add(input logic [9:0] stim, input logic [31:0] pc, input logic [31:0] tpc,
                                input logic [3:0] flags, input logic [2:0] cause, input logic [31:0] dpc);
        vec_t v;
        v.stim  = stim;
        v.pc    = pc;
        v.tpc   = tpc;
        v.flags = flags;
        v.cause = cause;
        v.dpc   = dpc;
        vecs.push_back(v);
    endfunction

    task automatic applyStimulus(input logic [9:0] stim, input logic [31:0] pc, input logic [31:0] tpc);
        rst                  = stim[9];
        busA.dm_halt_req     = stim[8];
        busA.dm_resume_req   = stim[7];
        busA.dm_step_en      = stim[6];
        busA.dm_ebreakm      = stim[5];
        busA.wb_ebreak       = stim[4];
        busA.wb_retire       = stim[3];
        busA.trap_jump_valid = stim[2];
        busA.lsu2ac_hazard   = stim[1];
        busA.wb2ac_hazard    = stim[0];
        busA.retire_next_pc  = pc;
        busA.trap_jump_pc    = tpc;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic logic [3:0] flagsA();
        return {busA.dbg2ac_stall, busA.dm_halted, busA.dm_resume_ack, busA.dbg_halt_timeout};
    endfunction

    initial begin
        exp_t e;
        int   k;

        // Reset, then a halt with no hazards; halt_req ignored while halted; resume ignored in RUN
        add(RST,  0,   0, NONE,    3'd0, 32'h0);
        add(IDLE, P40, 0, NONE,    3'd0, 32'h0);
        add(HRQ,  P40, 0, ST,      3'd3, P40);
        add(IDLE, P40, 0, ST | HL, 3'd3, P40);
        add(HRQ,  P44, 0, ST | HL, 3'd3, P40);
        add(RSM,  0,   0, AK,      3'd3, P40);
        add(IDLE, 0,   0, NONE,    3'd3, P40);
        add(RSM,  0,   0, NONE,    3'd3, P40);

        // Halt while the LSU drains for six cycles, then a single step retiring one instruction
        add(HRQ | LSU, P80, 0, ST, 3'd3, P80);
        for (int i = 0; i < 5; i++) add(LSU, 0, 0, ST, 3'd3, P80);
        add(IDLE,      0,   0, ST | HL, 3'd3, P80);
        add(RSM | STP, 0,   0, AK,      3'd3, P80);
        add(IDLE,      0,   0, NONE,    3'd3, P80);
        add(IDLE,      0,   0, NONE,    3'd3, P80);
        add(RET,       P44, 0, ST,      3'd4, P44);
        add(IDLE,      0,   0, ST | HL, 3'd4, P44);

        // Simultaneous events: ebreak beats haltreq; in STEP a trap beats the retire PC
        add(RSM,             0,    0,    AK,      3'd4, P44);
        add(IDLE,            0,    0,    NONE,    3'd4, P44);
        add(EBK | EBM | HRQ, P200, 0,    ST,      3'd1, P200);
        add(IDLE,            0,    0,    ST | HL, 3'd1, P200);
        add(RSM | STP,       0,    0,    AK,      3'd1, P200);
        add(IDLE,            0,    0,    NONE,    3'd1, P200);
        add(TRV | RET,       P44,  P100, ST,      3'd4, P100);
        add(IDLE,            0,    0,    ST | HL, 3'd4, P100);

        // Halt coinciding with a trap redirect captures the trap target; ebreak without ebreakm is ignored
        add(RSM,       0,    0,    AK,      3'd4, P100);
        add(IDLE,      0,    0,    NONE,    3'd4, P100);
        add(HRQ | TRV, P300, P400, ST,      3'd3, P400);
        add(IDLE,      0,    0,    ST | HL, 3'd3, P400);
        add(RSM,       0,    0,    AK,      3'd3, P400);
        add(IDLE,      0,    0,    NONE,    3'd3, P400);
        add(EBK,       P500, 0,    NONE,    3'd3, P400);
        add(IDLE,      0,    0,    NONE,    3'd3, P400);

        // Reset in the second DRAIN cycle, then a clean halt again
        add(HRQ | LSU, P500, 0, ST,      3'd3, P500);
        add(LSU,       0,    0, ST,      3'd3, P500);
        add(RST | LSU, 0,    0, NONE,    3'd0, 32'h0);
        add(IDLE,      P40,  0, NONE,    3'd0, 32'h0);
        add(HRQ,       P40,  0, ST,      3'd3, P40);
        add(IDLE,      P40,  0, ST | HL, 3'd3, P40);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].stim, vecs[i].pc, vecs[i].tpc);
            e.flags = vecs[i].flags;
            e.cause = vecs[i].cause;
            e.dpc   = vecs[i].dpc;
            e.idx   = i;
            sb.push_back(e);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            checkOutput($sformatf("row%0d flags", e.idx), {28'h0, flagsA()}, {28'h0, e.flags});
            checkOutput($sformatf("row%0d cause", e.idx), {29'h0, busA.dbg_cause}, {29'h0, e.cause});
            checkOutput($sformatf("row%0d dpc", e.idx), busA.dbg_dpc, e.dpc);
        end

        // Drain timeout on the short-limit instance with the writeback hazard stuck high
        applyStimulus(RST, 0, 0);
        @(posedge clk); #1;
        applyStimulus(HRQ | WBH, P300, 0);
        @(posedge clk); #1;
        checkOutput("timeout entry stall", {31'h0, busB.dbg2ac_stall}, 32'h1);
        applyStimulus(WBH, 0, 0);
        k = 1;
        while (k <= 40) begin
            @(posedge clk); #1;
            if (busB.dm_halted) break;
            k++;
        end
        checkOutput("timeout halt latency", k, SHORT_TO + 1);
        checkOutput("timeout flag set", {31'h0, busB.dbg_halt_timeout}, 32'h1);
        checkOutput("timeout cause", {29'h0, busB.dbg_cause}, 32'h3);
        checkOutput("timeout dpc", busB.dbg_dpc, P300);
        applyStimulus(IDLE, 0, 0);
        @(posedge clk); #1;
        checkOutput("timeout flag sticky", {31'h0, busB.dbg_halt_timeout}, 32'h1);
        applyStimulus(RSM, 0, 0);
        @(posedge clk); #1;
        checkOutput("resume ack pulse", {31'h0, busB.dm_resume_ack}, 32'h1);
        checkOutput("resume clears timeout", {31'h0, busB.dbg_halt_timeout}, 32'h0);
        checkOutput("resume halted low", {31'h0, busB.dm_halted}, 32'h0);
        checkOutput("resume stall low", {31'h0, busB.dbg2ac_stall}, 32'h0);
        applyStimulus(IDLE, 0, 0);
        @(posedge clk); #1;
        checkOutput("resume ack one cycle", {31'h0, busB.dm_resume_ack}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
